// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the core-to-memory bridge: access sizes, MMIO map,
// TX status layout and lane helpers.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_addr_t;

  localparam int          MMIO_SEL_BIT = 31;
  localparam logic [31:0] MMIO_BASE    = 32'h8000_0000;

  typedef enum logic [1:0] {
    OFF_TX       = 2'd0,
    OFF_MTIME_LO = 2'd1,
    OFF_MTIME_HI = 2'd2,
    OFF_TOHOST   = 2'd3
  } mmio_off_t;

  localparam int ST_OVERFLOW_BIT = 31;
  localparam int ST_COUNT_LSB    = 8;
  localparam int ST_COUNT_W      = 8;
  localparam int ST_FULL_BIT     = 1;
  localparam int ST_EMPTY_BIT    = 0;

  typedef enum logic [1:0] {
    RSEL_NONE = 2'd0,
    RSEL_RAM  = 2'd1,
    RSEL_MMIO = 2'd2
  } rd_sel_t;

  function automatic logic [3:0] lane_mask(input mem_addr_t size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: lane_mask = 4'b0001 << off;
      SIZE_HALF: lane_mask = 4'b0011 << off;
      default:   lane_mask = 4'b1111;
    endcase
  endfunction

  // Narrow stores are replicated so the byte enables alone pick the lane.
  function automatic logic [31:0] lane_data(input mem_addr_t size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: lane_data = {4{data[7:0]}};
      SIZE_HALF: lane_data = {2{data[15:0]}};
      default:   lane_data = data;
    endcase
  endfunction

endpackage

// File: rtl/mem_bridge_byte_fifo.sv
// Byte-wide FIFO for the UART TX path; head entry is visible combinationally
// and a push into an empty FIFO becomes visible only on the following cycle.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PW+1)'(DEPTH));
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/mem_bridge.sv
// Core data-port bridge: RAM passthrough with lane masks, plus MMIO for a
// UART TX FIFO, a free-running 64-bit mtime and a tohost halt register.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int RAM_AW     = 14,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_addr,
  input  logic              mem_rden,
  input  logic              mem_wren,
  input  mem_addr_t         mem_size,
  input  logic [31:0]       memwrite_data,
  output logic [31:0]       memread_data,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              halt,
  output logic              misalign
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic        access;
  logic        mis_access;
  logic        ok;
  logic        wr_op;
  logic        rd_op;
  logic        is_mmio;
  mmio_off_t   off;

  logic        tx_push_req;
  logic        tx_accept;
  logic        fifo_full;
  logic        fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0] tx_status;

  logic [63:0] mtime_reg;
  logic [31:0] snap_reg;
  logic [31:0] tohost_reg;
  logic        halt_reg;
  logic        misalign_reg;
  logic        overflow_reg;
  rd_sel_t     rd_sel_reg;
  logic [31:0] mmio_rdata_reg;

  logic        unused_bits;
  assign unused_bits = ^{mem_addr};

  assign access  = mem_rden | mem_wren;
  assign is_mmio = mem_addr[MMIO_SEL_BIT];
  assign off     = mmio_off_t'(mem_addr[3:2]);

  always_comb begin
    mis_access = 1'b0;
    case (mem_size)
      SIZE_HALF: mis_access = mem_addr[0];
      SIZE_WORD: mis_access = |mem_addr[1:0];
      default:   mis_access = 1'b0;
    endcase
    mis_access = mis_access & access;
  end

  // rden together with wren is a write; the read half is simply dropped.
  assign ok    = access & ~mis_access;
  assign wr_op = ok & mem_wren;
  assign rd_op = ok & mem_rden & ~mem_wren;

  assign ram_en    = ok & ~is_mmio;
  assign ram_we    = wr_op & ~is_mmio;
  assign ram_addr  = mem_addr[RAM_AW+1:2];
  assign ram_be    = ram_we ? lane_mask(mem_size, mem_addr[1:0]) : 4'b0000;
  assign ram_wdata = lane_data(mem_size, memwrite_data);

  assign tx_push_req = wr_op & is_mmio & (off == OFF_TX);
  assign tx_accept   = tx_push_req & (~fifo_full | (tx_valid & tx_ready));
  assign tx_valid    = ~fifo_empty;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_byte_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_accept),
    .din   (memwrite_data[7:0]),
    .pop   (tx_ready),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    tx_status = '0;
    tx_status[ST_OVERFLOW_BIT]                         = overflow_reg;
    tx_status[ST_COUNT_LSB +: ST_COUNT_W]              = ST_COUNT_W'(fifo_count);
    tx_status[ST_FULL_BIT]                             = fifo_full;
    tx_status[ST_EMPTY_BIT]                            = fifo_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_reg      <= '0;
      snap_reg       <= '0;
      tohost_reg     <= '0;
      halt_reg       <= 1'b0;
      misalign_reg   <= 1'b0;
      overflow_reg   <= 1'b0;
      rd_sel_reg     <= RSEL_NONE;
      mmio_rdata_reg <= '0;
    end else begin
      mtime_reg    <= mtime_reg + 64'd1;
      misalign_reg <= mis_access;
      if (tx_push_req & ~tx_accept) overflow_reg <= 1'b1;
      if (wr_op & is_mmio & (off == OFF_TOHOST)) begin
        tohost_reg <= memwrite_data;
        if (|memwrite_data) halt_reg <= 1'b1;
      end
      rd_sel_reg <= RSEL_NONE;
      if (rd_op) begin
        if (!is_mmio) begin
          rd_sel_reg <= RSEL_RAM;
        end else begin
          rd_sel_reg <= RSEL_MMIO;
          case (off)
            OFF_TX:       mmio_rdata_reg <= tx_status;
            // Snapshot the high half so a LO-then-HI pair reads a coherent value.
            OFF_MTIME_LO: begin
              mmio_rdata_reg <= mtime_reg[31:0];
              snap_reg       <= mtime_reg[63:32];
            end
            OFF_MTIME_HI: mmio_rdata_reg <= snap_reg;
            default:      mmio_rdata_reg <= tohost_reg;
          endcase
        end
      end
    end
  end

  always_comb begin
    case (rd_sel_reg)
      RSEL_RAM:  memread_data = ram_rdata;
      RSEL_MMIO: memread_data = mmio_rdata_reg;
      default:   memread_data = '0;
    endcase
  end

  assign halt     = halt_reg;
  assign misalign = misalign_reg;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: RAM lanes, misalignment, TX FIFO, mtime
// snapshot, tohost halt and asynchronous reset.
module tb_mem_bridge;
  import mem_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_rden;
  logic        mem_wren;
  mem_addr_t   mem_size;
  logic [31:0] memwrite_data;
  logic [31:0] memread_data;
  logic [13:0] ram_addr;
  logic        ram_en;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halt;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bridge #(
    .RAM_AW     (14),
    .FIFO_DEPTH (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_addr      (mem_addr),
    .mem_rden      (mem_rden),
    .mem_wren      (mem_wren),
    .mem_size      (mem_size),
    .memwrite_data (memwrite_data),
    .memread_data  (memread_data),
    .ram_addr      (ram_addr),
    .ram_en        (ram_en),
    .ram_we        (ram_we),
    .ram_be        (ram_be),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .halt          (halt),
    .misalign      (misalign)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input mem_addr_t sz,
                       input logic [31:0] a, input logic [31:0] d);
    mem_rden      = rd;
    mem_wren      = wr;
    mem_size      = sz;
    mem_addr      = a;
    memwrite_data = d;
    if (rd | wr)
      $display("[%0t] txn rd=%0b wr=%0b size=%0d addr=0x%08h data=0x%08h",
               $time, rd, wr, sz, a, d);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
  endtask

  initial begin
    rst       = 1'b1;
    tx_ready  = 1'b0;
    ram_rdata = 32'h0;
    idle();
    #12;
    check("rst_memread", memread_data, 32'h0);
    check("rst_halt", 32'(halt), 32'h0);
    check("rst_misalign", 32'(misalign), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    // RAM path stays combinational while reset is held
    drive(1'b0, 1'b1, SIZE_BYTE, 32'h6, 32'hAB);
    #1;
    check("rst_ram_en", 32'(ram_en), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    idle();

    // byte store
    @(negedge clk);
    drive(1'b0, 1'b1, SIZE_BYTE, 32'h0000_0006, 32'h0000_00AB);
    #1;
    check("sb_be", 32'(ram_be), 32'h4);
    check("sb_wdata", ram_wdata, 32'hABAB_ABAB);
    check("sb_addr", 32'(ram_addr), 32'h1);
    check("sb_we", 32'(ram_we), 32'h1);

    // half store
    @(negedge clk);
    drive(1'b0, 1'b1, SIZE_HALF, 32'h0000_0002, 32'h0000_1234);
    #1;
    check("sh_be", 32'(ram_be), 32'hC);
    check("sh_wdata", ram_wdata, 32'h1234_1234);

    // word store
    @(negedge clk);
    drive(1'b0, 1'b1, SIZE_WORD, 32'h0000_0008, 32'hCAFE_F00D);
    #1;
    check("sw_be", 32'(ram_be), 32'hF);
    check("sw_addr", 32'(ram_addr), 32'h2);
    check("sw_wdata", ram_wdata, 32'hCAFE_F00D);

    // word load with one-cycle latency
    @(negedge clk);
    drive(1'b1, 1'b0, SIZE_WORD, 32'h0000_0010, 32'h0);
    #1;
    check("lw_en", 32'(ram_en), 32'h1);
    check("lw_we", 32'(ram_we), 32'h0);
    @(posedge clk);
    #1;
    ram_rdata = 32'hDEAD_BEEF;
    idle();
    #1;
    check("lw_data", memread_data, 32'hDEAD_BEEF);

    // misaligned word load
    @(negedge clk);
    drive(1'b1, 1'b0, SIZE_WORD, 32'h0000_0002, 32'h0);
    #1;
    check("mis_ram_en", 32'(ram_en), 32'h0);
    @(posedge clk);
    #1;
    idle();
    check("mis_pulse", 32'(misalign), 32'h1);
    check("mis_no_read", memread_data, 32'h0);
    @(posedge clk);
    #1;
    check("mis_pulse_end", 32'(misalign), 32'h0);

    // misaligned tohost store must not halt
    @(negedge clk);
    drive(1'b0, 1'b1, SIZE_WORD, 32'h8000_000E, 32'h5);
    @(posedge clk);
    #1;
    idle();
    check("mis_tohost_halt", 32'(halt), 32'h0);
    check("mis_tohost_pulse", 32'(misalign), 32'h1);

    // fill TX FIFO past capacity with the sink stalled
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, SIZE_BYTE, MMIO_BASE, 32'(32'h41 + i));
    end
    @(posedge clk);
    #1;
    idle();
    check("fill_valid", 32'(tx_valid), 32'h1);
    check("fill_head", 32'(tx_data), 32'h41);
    @(negedge clk);
    drive(1'b1, 1'b0, SIZE_WORD, MMIO_BASE, 32'h0);
    @(posedge clk);
    #1;
    idle();
    check("full_status", memread_data, 32'h8000_0802);

    // drain in order
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 32'(tx_valid), 32'h1);
      check("drain_data", 32'(tx_data), 32'(32'h41 + i));
      @(negedge clk);
    end
    check("drain_empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;
    drive(1'b1, 1'b0, SIZE_WORD, MMIO_BASE, 32'h0);
    @(posedge clk);
    #1;
    idle();
    check("empty_status", memread_data, 32'h8000_0001);

    // push into empty FIFO with the sink ready: no bypass
    @(negedge clk);
    tx_ready = 1'b1;
    drive(1'b0, 1'b1, SIZE_BYTE, MMIO_BASE, 32'h55);
    #1;
    check("nobypass_valid", 32'(tx_valid), 32'h0);
    @(posedge clk);
    #1;
    idle();
    check("push_valid", 32'(tx_valid), 32'h1);
    check("push_data", 32'(tx_data), 32'h55);
    @(posedge clk);
    #1;
    check("push_popped", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    // mtime low/high snapshot across the 32-bit carry
    @(negedge clk);
    force dut.mtime_reg = 64'h0000_0000_FFFF_FFFF;
    drive(1'b1, 1'b0, SIZE_WORD, 32'h8000_0004, 32'h0);
    @(posedge clk);
    #1;
    idle();
    check("mtime_lo", memread_data, 32'hFFFF_FFFF);
    @(negedge clk);
    release dut.mtime_reg;
    @(negedge clk);
    drive(1'b1, 1'b0, SIZE_WORD, 32'h8000_0008, 32'h0);
    @(posedge clk);
    #1;
    idle();
    check("mtime_hi_snap", memread_data, 32'h0);

    // tohost halt
    @(negedge clk);
    drive(1'b0, 1'b1, SIZE_WORD, 32'h8000_000C, 32'h1);
    #1;
    check("halt_before", 32'(halt), 32'h0);
    @(posedge clk);
    #1;
    idle();
    check("halt_set", 32'(halt), 32'h1);
    @(negedge clk);
    drive(1'b1, 1'b0, SIZE_WORD, 32'h8000_000C, 32'h0);
    @(posedge clk);
    #1;
    idle();
    check("tohost_read", memread_data, 32'h1);

    // queue bytes, then reset asynchronously mid-cycle
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, SIZE_BYTE, MMIO_BASE, 32'(32'h60 + i));
    end
    @(negedge clk);
    idle();
    check("pre_rst_valid", 32'(tx_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_halt", 32'(halt), 32'h0);
    check("async_tx_valid", 32'(tx_valid), 32'h0);
    check("async_memread", memread_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(1'b1, 1'b0, SIZE_WORD, MMIO_BASE, 32'h0);
    @(posedge clk);
    #1;
    idle();
    check("post_rst_status", memread_data, 32'h0000_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 The block SHALL have parameter RAM_AW, default 14, meaning the RAM word-address width (64 KiB).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning TX FIFO entries, a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1, the single clock, with all state on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have ports mem_addr, mem_rden, mem_wren, mem_size, memwrite_data: inputs of 32/1/1/mem_addr_t/32 bits from the core.
REQ-006 The block SHALL have port memread_data, output, 32, read data to the core.
REQ-007 The block SHALL have ports ram_addr (RAM_AW), ram_en (1), ram_we (1), ram_be (4) and ram_wdata (32), all outputs to a synchronous single-port RAM.
REQ-008 The block SHALL have port ram_rdata, input, 32, RAM data, valid one cycle after ram_en with ram_we low.
REQ-009 The block SHALL have ports tx_valid (output, 1), tx_data (output, 8) and tx_ready (input, 1) forming the byte-stream handshake to the UART.
REQ-010 The block SHALL have ports halt (output, 1, sticky tohost-written flag) and misalign (output, 1, one-cycle error pulse).

Function
REQ-011 Decode: mem_addr[31]=0 SHALL select RAM and mem_addr[31]=1 SHALL select MMIO, with MMIO offset mem_addr[3:2] selecting 0=TX, 1=MTIME_LO, 2=MTIME_HI, 3=TOHOST.
REQ-012 Misalignment SHALL be defined as half access with addr[0]=1, or word access with addr[1:0]≠0; such an access SHALL suppress all side effects and pulse misalign for one cycle.
REQ-013 A RAM access SHALL be combinational passthrough: ram_en=rden|wren, ram_addr=mem_addr[RAM_AW+1:2].
REQ-014 Writes SHALL produce lane masks ram_be: byte 0001<<addr[1:0], half 0011<<addr[1:0], word 1111; ram_wdata SHALL be memwrite_data low byte/half replicated across lanes.
REQ-015 Reads SHALL have 1-cycle latency: memread_data SHALL equal ram_rdata or the registered MMIO read value per a registered select, returning the raw aligned word with extraction done by the core.
REQ-016 A TX write SHALL push memwrite_data[7:0] when not full, and when full SHALL drop the byte and set sticky overflow.
REQ-017 A TX read SHALL return {overflow at bit 31, 0, count at bits[15:8], full at bit 1, empty at bit 0}.
REQ-018 The FIFO SHALL present the head entry with tx_valid=!empty, and the head SHALL pop on tx_valid&tx_ready.
REQ-019 A simultaneous push and pop when full SHALL be accepted, leaving count unchanged, and a simultaneous push and pop when empty SHALL not bypass, so the byte appears the next cycle.
REQ-020 Pointers SHALL wrap modulo FIFO_DEPTH, and count SHALL span 0..FIFO_DEPTH.
REQ-021 mtime SHALL be a 64-bit counter incrementing every cycle and wrapping from all ones to 0.
REQ-022 A MTIME_LO read SHALL return the low half and snapshot the high half, and a MTIME_HI read SHALL return that snapshot; MTIME writes SHALL be ignored.
REQ-023 A TOHOST write with nonzero data SHALL set halt, held until reset, and a TOHOST read SHALL return the last written value.
REQ-024 rden and wren both high SHALL be treated as a write, with read data undefined.

Reset
REQ-025 Reset SHALL clear FIFO pointers/count, overflow, mtime, snapshot, tohost, halt, misalign, tx_valid and the read-select register, and SHALL drive memread_data to 0.
REQ-026 Reset mid-drain SHALL drop tx_valid immediately and discard FIFO contents, and RAM outputs SHALL be combinational, unaffected by reset.

Structure
REQ-027 mem_addr_t size encodings, MMIO base and offsets, and status bit positions SHALL live in the shared core package.
REQ-028 The FIFO SHALL be a sub-module named byte_fifo (parameter DEPTH, push/pop/full/empty/count), and no other sub-modules SHALL be used.

Verification
REQ-029 A bench SHALL check: sb to 0x0000_0006 with data 0xAB -> ram_be=0100, ram_wdata=0xABABABAB, ram_addr=1.
REQ-030 A bench SHALL check: 9 TX writes 0x41..0x49 with tx_ready=0 -> full after 8, overflow=1, status=0x8000_0802; then tx_ready=1 -> 0x41..0x48 drained in order.
REQ-031 A bench SHALL check: tx_ready=1 held with a push on an empty FIFO -> tx_valid rises the next cycle and pops the same cycle.
REQ-032 A bench SHALL check: mtime forced to 0xFFFFFFFF -> read LO=0xFFFFFFFF, HI=snapshot 0, not the post-carry 1.
REQ-033 A bench SHALL check: lw at 0x0000_0002 -> misalign pulse, ram_en=0, no state change.
REQ-034 A bench SHALL check: sw of 1 to TOHOST -> halt=1 next cycle, and rst asserted asynchronously mid-cycle -> halt=0 and tx_valid=0 immediately.
